// File: rtl/hadamard_2d.sv
// 4x4 two-dimensional Walsh-Hadamard transform: four row passes, then four column
// passes, one row or column per clock, then a single-cycle done pulse.
module hadamard_2d #(
  parameter int IMG_ROWS = 4,
  parameter int IMG_COLS = 4,
  parameter int DW       = 32
) (
  input  logic                                   clock,
  input  logic                                   reset_L,
  input  logic                                   start,
  input  logic [IMG_ROWS-1:0][IMG_COLS-1:0][DW-1:0] image_in,
  output logic                                   busy,
  output logic                                   done,
  output logic [IMG_ROWS-1:0][IMG_COLS-1:0][DW-1:0] spectrum_out
);

  typedef enum logic [1:0] {IDLE, ROW, COL, DONE} state_t;

  state_t state, next_state;
  logic [1:0] idx;
  logic [IMG_ROWS-1:0][IMG_COLS-1:0][DW-1:0] work_buf, row_next, col_next;
  logic [IMG_ROWS-1:0][DW-1:0] col_vec, col_res;

  // Two butterfly levels; all arithmetic wraps at DW bits.
  function automatic logic [3:0][DW-1:0] ht4(input logic [3:0][DW-1:0] x);
    logic [DW-1:0] s0, d0, s1, d1;
    s0 = x[0] + x[1];
    d0 = x[0] - x[1];
    s1 = x[2] + x[3];
    d1 = x[2] - x[3];
    ht4[0] = s0 + s1;
    ht4[1] = d0 + d1;
    ht4[2] = s0 - s1;
    ht4[3] = d0 - d1;
  endfunction

  always_comb begin
    row_next      = work_buf;
    row_next[idx] = ht4(work_buf[idx]);
    col_vec       = '0;
    for (int r = 0; r < IMG_ROWS; r++) col_vec[r] = work_buf[r][idx];
    col_res  = ht4(col_vec);
    col_next = work_buf;
    for (int r = 0; r < IMG_ROWS; r++) col_next[r][idx] = col_res[r];
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ROW;
      ROW:     if (idx == 2'd3) next_state = COL;
      COL:     if (idx == 2'd3) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_L) state <= IDLE;
    else          state <= next_state;
  end

  // idx wraps 3 -> 0 naturally, which sets up the column pass and the next image.
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      work_buf     <= '0;
      idx          <= 2'd0;
      spectrum_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          idx <= 2'd0;
          if (start) work_buf <= image_in;
        end
        ROW: begin
          work_buf <= row_next;
          idx      <= idx + 2'd1;
        end
        COL: begin
          work_buf <= col_next;
          idx      <= idx + 2'd1;
          if (idx == 2'd3) spectrum_out <= col_next;
        end
        default: idx <= 2'd0;
      endcase
    end
  end

  assign busy = (state == ROW) || (state == COL);
  assign done = (state == DONE);

endmodule

// File: tb/tb_hadamard_2d.sv
// Directed checks of hadamard_2d against hand-computed spectra, latency, start
// handling and reset behaviour.
module tb_hadamard_2d;

  typedef logic [3:0][3:0][31:0] img_t;

  logic clock = 1'b0;
  logic reset_L;
  logic start;
  img_t image_in;
  logic busy;
  logic done;
  img_t spectrum_out;

  int errors = 0;
  int checks = 0;

  hadamard_2d #(.IMG_ROWS(4), .IMG_COLS(4), .DW(32)) dut (
    .clock        (clock),
    .reset_L      (reset_L),
    .start        (start),
    .image_in     (image_in),
    .busy         (busy),
    .done         (done),
    .spectrum_out (spectrum_out)
  );

  always #5 clock = ~clock;

  // Pulses start with img and returns edges from acceptance until done is seen.
  task automatic run_transform(input img_t img, output int edges_to_done,
                               output int busy_cycles, output bit timed_out);
    @(negedge clock);
    image_in = img;
    start    = 1'b1;
    @(negedge clock);
    start         = 1'b0;
    image_in      = '0;
    edges_to_done = 0;
    busy_cycles   = 0;
    timed_out     = 1'b0;
    while (!done && edges_to_done < 30) begin
      if (busy) busy_cycles++;
      @(negedge clock);
      edges_to_done++;
    end
    if (!done) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    start    = 1'b0;
    image_in = '1;
    reset_L  = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || spectrum_out !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state busy=%b done=%b spec=%h required 0 0 0", busy, done, spectrum_out);
    end
    reset_L = 1'b1;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_start_after_reset busy=%b required 1", busy);
    end
    repeat (12) @(negedge clock);
  endtask

  task automatic test_all_ones();
    img_t img, exp;
    int e, b;
    bit to;
    img = '0;
    exp = '0;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r][c] = 32'd1;
    exp[0][0] = 32'd16;
    run_transform(img, e, b, to);
    checks++;
    if (to || e != 8) begin
      errors++;
      $display("[TB] FAIL ones_latency edges=%0d timeout=%0d required 8", e, to);
    end
    checks++;
    if (b != 8) begin
      errors++;
      $display("[TB] FAIL ones_busy_cycles got=%0d required 8", b);
    end
    checks++;
    if (spectrum_out !== exp) begin
      errors++;
      $display("[TB] FAIL ones_spectrum got=%h required %h", spectrum_out, exp);
    end
    @(negedge clock);
    image_in = '1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ones_done_single done=%b busy=%b required 0 0", done, busy);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (spectrum_out !== exp) begin
      errors++;
      $display("[TB] FAIL ones_spectrum_hold got=%h required %h", spectrum_out, exp);
    end
  endtask

  task automatic test_border();
    img_t img, exp;
    int e, b;
    bit to;
    exp = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        img[r][c] = (r >= 1 && r <= 2 && c >= 1 && c <= 2) ? 32'd1 : 32'hFFFF_FFFF;
    exp[0][0] = 32'hFFFF_FFF8;
    exp[0][3] = 32'hFFFF_FFF8;
    exp[3][0] = 32'hFFFF_FFF8;
    exp[3][3] = 32'd8;
    run_transform(img, e, b, to);
    checks++;
    if (to || e != 8 || spectrum_out !== exp) begin
      errors++;
      $display("[TB] FAIL border_spectrum edges=%0d got=%h required %h", e, spectrum_out, exp);
    end
  endtask

  task automatic test_impulse();
    img_t img, exp;
    int e, b;
    bit to;
    img = '0;
    img[0][0] = 32'd1;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) exp[r][c] = 32'd1;
    run_transform(img, e, b, to);
    checks++;
    if (to || spectrum_out !== exp) begin
      errors++;
      $display("[TB] FAIL impulse_spectrum got=%h required %h", spectrum_out, exp);
    end
  endtask

  task automatic test_wrap();
    img_t img, exp;
    int e, b;
    bit to;
    exp = '0;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r][c] = 32'h7FFF_FFFF;
    exp[0][0] = 32'hFFFF_FFF0;
    run_transform(img, e, b, to);
    checks++;
    if (to || spectrum_out !== exp) begin
      errors++;
      $display("[TB] FAIL wrap_spectrum got=%h required %h", spectrum_out, exp);
    end
  endtask

  task automatic test_start_held();
    img_t img, exp;
    int n;
    img = '0;
    img[0][0] = 32'd1;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) exp[r][c] = 32'd1;
    @(negedge clock);
    image_in = img;
    start    = 1'b1;
    @(negedge clock);
    n = 0;
    while (!done && n < 30) begin
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) image_in[r][c] = $urandom;
      @(negedge clock);
      n++;
    end
    checks++;
    if (!done || n != 8 || spectrum_out !== exp) begin
      errors++;
      $display("[TB] FAIL held_start_spectrum edges=%0d got=%h required %h", n, spectrum_out, exp);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL held_start_idle busy=%b done=%b required 0 0", busy, done);
    end
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL held_start_reaccept busy=%b required 1", busy);
    end
    n = 0;
    while (!done && n < 30) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
  endtask

  task automatic test_reset_during_col();
    img_t img, exp;
    int e, b, n;
    bit to, early;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r][c] = 32'd1;
    exp = '0;
    exp[0][0] = 32'd16;
    @(negedge clock);
    image_in = img;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    reset_L = 1'b0;
    start   = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || spectrum_out !== '0) begin
      errors++;
      $display("[TB] FAIL col_reset busy=%b done=%b spec=%h required 0 0 0", busy, done, spectrum_out);
    end
    start   = 1'b0;
    reset_L = 1'b1;
    early   = 1'b0;
    for (n = 0; n < 12; n++) begin
      @(negedge clock);
      if (done || busy) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("[TB] FAIL aborted_run_activity seen=%b required 0", early);
    end
    run_transform(img, e, b, to);
    checks++;
    if (to || e != 8 || spectrum_out !== exp) begin
      errors++;
      $display("[TB] FAIL fresh_after_abort edges=%0d got=%h required %h", e, spectrum_out, exp);
    end
  endtask

  initial begin
    reset_L  = 1'b0;
    start    = 1'b0;
    image_in = '0;
    test_reset();
    test_all_ones();
    test_border();
    test_impulse();
    test_wrap();
    test_start_held();
    test_reset_during_col();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hadamard_2d.md
HADAMARD_2D -- requirements
Module: hadamard_2d

Interface
REQ-001 Parameter IMG_ROWS, default 4, number of image rows; SHALL be fixed at 4 (4-point transform only).
REQ-002 Parameter IMG_COLS, default 4, number of image columns; SHALL be fixed at 4.
REQ-003 Parameter DW, default 32, width of every pixel and coefficient in two's complement.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset, with ports clock and reset_L.
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset_L  input  1  synchronous active-low reset.
REQ-007 start  input  1  request to transform image_in; honoured only in IDLE.
REQ-008 image_in  input  [IMG_ROWS-1:0][IMG_COLS-1:0][DW-1:0]  signed image, element [r][c] = row r, column c; this is the memory export stage output.
REQ-009 busy  output  1  high while a transform is in progress (ROW, COL states).
REQ-010 done  output  1  one-cycle pulse when spectrum_out has just been updated.
REQ-011 spectrum_out  output  [IMG_ROWS-1:0][IMG_COLS-1:0][DW-1:0]  registered 2-D Walsh-Hadamard coefficients, element [u][v].

Function
REQ-012 The FSM SHALL have states IDLE, ROW, COL, and DONE, plus a 2-bit index counter idx.
REQ-013 IDLE with start=1: on the edge, buf <= image_in, idx <= 0, go to ROW; IDLE with start=0: stay.
REQ-014 ROW: each edge replaces buf row idx with its 4-point transform, idx++; after idx=3, idx <= 0 and go to COL (4 edges total).
REQ-015 COL: each edge replaces buf column idx with its 4-point transform, idx++; on the idx=3 edge, spectrum_out <= final buf and go to DONE.
REQ-016 DONE: done=1 for exactly this one cycle; the next edge SHALL go to IDLE.
REQ-017 4-point transform of (a,b,c,d) SHALL be (a+b+c+d, a-b+c-d, a+b-c-d, a-b-c+d), computed as two butterfly levels.
REQ-018 All sums SHALL be DW bits, wrapping modulo 2^DW; no saturation and no width growth.
REQ-019 Latency: done SHALL be high in the cycle following the 8th rising edge after the edge that sampled start.
REQ-020 start in ROW, COL, or DONE SHALL be ignored, with no queueing and no restart.
REQ-021 image_in SHALL be sampled only on the accepting edge; later changes SHALL NOT affect the result.
REQ-022 spectrum_out SHALL hold its value between completions and change only on the DONE-entry edge.
REQ-023 busy and done SHALL be decoded from the state register (glitch-free, registered state).

Reset
REQ-024 reset_L=0 at an edge SHALL force IDLE, idx=0, buf=0, spectrum_out=0, busy=0, and done=0, from any state.
REQ-025 Reset SHALL take priority over start on the same edge.
REQ-026 After reset is released, start SHALL be accepted on the first edge it is sampled high.

Verification
REQ-027 All +1 image, start pulse -> done after 8 edges; spectrum_out[0][0]=16, all other elements 0; busy high for exactly 8 cycles.
REQ-028 Image with border -1 and centre [1..2][1..2]=+1 -> [0][0]=-8, [0][3]=-8, [3][0]=-8, [3][3]=+8, other 12 elements 0.
REQ-029 Impulse image[0][0]=1, rest 0 -> all 16 spectrum_out elements =1.
REQ-030 All pixels 32'h7FFF_FFFF -> [0][0]=32'hFFFF_FFF0 (wrap), others 0.
REQ-031 start held high continuously with image_in changed every cycle -> result matches the image on the accepting edge; next acceptance is the edge after DONE.
REQ-032 reset_L=0 during COL -> next cycle busy=0, done=0, spectrum_out=0; a fresh start then completes correctly with no done from the aborted run.
